hazard_detection_unit: RTL
==========================

# hazard_detection_unit

Decides when the 16-bit pipeline stalls, bubbles or flushes because forwarding into EX cannot resolve a dependence in time. It sits in the ID stage, directly upstream of the EX-stage forwarding logic. It inspects the instruction in IF/ID against producers in ID/EX and EX/MEM and drives PC / IF/ID write enables, ID/EX bubble insertion and IF/ID squash. A small FSM handles two-cycle branch stalls and halt draining, and a saturating counter records stall cycles.

## Interface
- No parameters (16 architectural registers, 4-bit specifiers, R0 reads as zero).
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- IFID_Rs, IFID_Rt  in  4 each  source specifiers of instruction in ID.
- IFID_UsesRs, IFID_UsesRt  in  1 each  instruction actually reads that source.
- IFID_IsStore  in  1  ID instruction is SW (its Rt is store data).
- IFID_IsBR  in  1  register-indirect branch; target read from Rs in ID.
- IFID_IsB  in  1  conditional branch on flags.
- IFID_IsHalt  in  1  HLT in ID.
- BranchTaken  in  1  ID branch resolution result.
- IDEX_MemRead, IDEX_RegWrite, IDEX_SetsFlags  in  1 each  control of instruction in EX.
- IDEX_Rd  in  4  destination of instruction in EX.
- EXMem_MemRead  in  1;  EXMem_Rd  in  4  load in MEM.
- PC_Write  out  1  PC may update.
- IFID_Write  out  1  IF/ID may capture.
- IDEX_Bubble  out  1  zero ID/EX control next edge (NOP).
- IFID_Flush  out  1  load NOP into IF/ID next edge.
- Halted  out  1  registered; core halted.
- StallCount  out  16  registered saturating count of bubble cycles.

## Operation
- Hazard terms (each requires the relevant Rd != 0):
  - LU: IDEX_MemRead & ((UsesRs & IDEX_Rd==Rs) | (UsesRt & IDEX_Rd==Rt & !IsStore)). Store data is excluded; MEM-to-MEM forwarding covers it.
  - BA: IsBR & IDEX_RegWrite & !IDEX_MemRead & IDEX_Rd==Rs.
  - BL2: IsBR & IDEX_MemRead & IDEX_Rd==Rs.
  - BL1: IsBR & EXMem_MemRead & EXMem_Rd==Rs.
  - BF: IsB & IDEX_SetsFlags.
- FSM states: RUN, STALL_LAST, HALT.
  - RUN, BL2 true: stall; next state STALL_LAST.
  - RUN, any of LU/BA/BL1/BF true (BL2 false): stall; stay in RUN.
  - RUN, no hazard, IsHalt: no stall, PC_Write=0, IFID_Flush=1; next state HALT.
  - STALL_LAST: stall unconditionally; hazard terms are not evaluated; next state RUN.
  - HALT: PC_Write=0, IFID_Write=1, IFID_Flush=1, IDEX_Bubble=0, Halted=1. Only rst leaves this state.
- Stall cycle outputs: PC_Write=0, IFID_Write=0, IDEX_Bubble=1, IFID_Flush=0. BranchTaken is ignored.
- RUN, no stall: PC_Write=1, IFID_Write=1, IDEX_Bubble=0. IFID_Flush=BranchTaken&(IsBR|IsB), or 1 for halt.
- Precedence in RUN: stall > halt > branch flush.
- StallCount: +1 at each edge where IDEX_Bubble=1. Saturates at 16'hFFFF with no wrap.

## Timing
- All hazard detection and outputs are combinational from the inputs and current state, in the same cycle. Only the state, Halted and StallCount are registered.
- LU, BA, BL1, BF: exactly 1 bubble. BL2: exactly 2 consecutive bubbles. The ID instruction stays held in IF/ID throughout.
- Taken branch: 1 squashed fetch. HLT: Halted rises the edge after HLT is seen in ID.
- While rst=1: PC_Write=1, IFID_Write=1, IDEX_Bubble=0, IFID_Flush=0. At that edge: state←RUN, Halted←0, StallCount←0.
- rst asserted in STALL_LAST or HALT aborts it: RUN from the next cycle, no residual bubble.
- Rd=0 never causes a stall. The producer's RegWrite is not checked for LU (a load always writes).

## Test plan
- LW R3 in EX, ADD using Rs=R3 in ID -> one cycle with PC_Write=0, IDEX_Bubble=1. Then normal; StallCount=1.
- LW R3 in EX, SW with Rt=R3, Rs=R5 in ID -> no stall. Same with Rs=R3 -> one stall.
- LW R4 in EX, BR Rs=R4 in ID -> two consecutive bubbles (STALL_LAST visited), then BranchTaken=1 gives IFID_Flush=1. StallCount=2.
- ADD R0 in EX with MemRead=1, ID reads R0 -> no stall. SUB setting flags in EX, B in ID -> one bubble.
- HLT in ID, no hazard -> PC_Write=0, IFID_Flush=1. Halted=1 next cycle and remains until rst.
- rst during STALL_LAST -> next cycle IDEX_Bubble=0, StallCount=0. Force 0xFFFF+ bubbles -> StallCount holds 16'hFFFF.

Source files
------------

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit
//
// Purpose: ID-stage hazard detection for the 16-bit pipeline. It decides when
// the pipeline stalls, inserts an ID/EX bubble or squashes IF/ID because EX
// forwarding cannot resolve a dependence in time. A three-state FSM covers
// two-cycle load-to-BR stalls and halt draining. A saturating counter records
// the number of bubble cycles.
//
// Ports:
//   clk, rst                   clock; synchronous active-high reset
//   IFID_Rs/Rt, UsesRs/UsesRt  sources of the ID instruction, and whether each is read
//   IFID_IsStore/IsBR/IsB/IsHalt  ID instruction class
//   BranchTaken                ID branch resolution
//   IDEX_MemRead/RegWrite/SetsFlags/Rd  producer currently in EX
//   EXMem_MemRead/Rd           load currently in MEM
//   PC_Write, IFID_Write       pipeline front-end write enables
//   IDEX_Bubble                force NOP into ID/EX at the next edge
//   IFID_Flush                 load NOP into IF/ID at the next edge
//   Halted                     registered halt flag
//   StallCount                 registered saturating count of bubble cycles

module hazard_detection_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  IFID_Rs,
    input  logic [3:0]  IFID_Rt,
    input  logic        IFID_UsesRs,
    input  logic        IFID_UsesRt,
    input  logic        IFID_IsStore,
    input  logic        IFID_IsBR,
    input  logic        IFID_IsB,
    input  logic        IFID_IsHalt,
    input  logic        BranchTaken,
    input  logic        IDEX_MemRead,
    input  logic        IDEX_RegWrite,
    input  logic        IDEX_SetsFlags,
    input  logic [3:0]  IDEX_Rd,
    input  logic        EXMem_MemRead,
    input  logic [3:0]  EXMem_Rd,
    output logic        PC_Write,
    output logic        IFID_Write,
    output logic        IDEX_Bubble,
    output logic        IFID_Flush,
    output logic        Halted,
    output logic [15:0] StallCount
);

    typedef enum logic [1:0] {
        StRun       = 2'd0,
        StStallLast = 2'd1,
        StHalt      = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        halted_q, halted_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // R0 is hardwired to zero, so a producer targeting it never blocks anyone.
    logic idex_rd_nz, exmem_rd_nz;
    logic haz_lu, haz_ba, haz_bl2, haz_bl1, haz_bf;
    logic haz_any;

    always_comb begin
        idex_rd_nz  = (IDEX_Rd != 4'd0);
        exmem_rd_nz = (EXMem_Rd != 4'd0);

        // Store data (Rt of SW) is excluded: MEM-to-MEM forwarding supplies it.
        haz_lu  = idex_rd_nz & IDEX_MemRead &
                  ((IFID_UsesRs & (IDEX_Rd == IFID_Rs)) |
                   (IFID_UsesRt & (IDEX_Rd == IFID_Rt) & ~IFID_IsStore));
        haz_ba  = idex_rd_nz & IFID_IsBR & IDEX_RegWrite & ~IDEX_MemRead &
                  (IDEX_Rd == IFID_Rs);
        haz_bl2 = idex_rd_nz & IFID_IsBR & IDEX_MemRead & (IDEX_Rd == IFID_Rs);
        haz_bl1 = exmem_rd_nz & IFID_IsBR & EXMem_MemRead & (EXMem_Rd == IFID_Rs);
        haz_bf  = IFID_IsB & IDEX_SetsFlags;
        haz_any = haz_lu | haz_ba | haz_bl2 | haz_bl1 | haz_bf;
    end

    // Next state and outputs.
    always_comb begin
        state_d     = state_q;
        PC_Write    = 1'b1;
        IFID_Write  = 1'b1;
        IDEX_Bubble = 1'b0;
        IFID_Flush  = 1'b0;

        if (rst) begin
            // Reset overrides everything, including a pending STALL_LAST or HALT.
            state_d = StRun;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (haz_any) begin
                        PC_Write    = 1'b0;
                        IFID_Write  = 1'b0;
                        IDEX_Bubble = 1'b1;
                        // Load to BR needs a second bubble before the value reaches ID.
                        if (haz_bl2) begin
                            state_d = StStallLast;
                        end
                    end else if (IFID_IsHalt) begin
                        PC_Write   = 1'b0;
                        IFID_Flush = 1'b1;
                        state_d    = StHalt;
                    end else begin
                        IFID_Flush = BranchTaken & (IFID_IsBR | IFID_IsB);
                    end
                end
                StStallLast: begin
                    PC_Write    = 1'b0;
                    IFID_Write  = 1'b0;
                    IDEX_Bubble = 1'b1;
                    state_d     = StRun;
                end
                StHalt: begin
                    PC_Write   = 1'b0;
                    IFID_Flush = 1'b1;
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end
    end

    always_comb begin
        halted_d    = (state_d == StHalt);
        stall_cnt_d = stall_cnt_q;
        if (IDEX_Bubble && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            halted_q    <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign Halted     = halted_q;
    assign StallCount = stall_cnt_q;

endmodule
